// File: rtl/video_timing_probe.sv
// video_timing_probe
// Measures line/frame geometry and an active-pixel checksum from the emulated
// VGA outputs. Video inputs are sampled only on ce_pix cycles.
//
// Ports:
//   clk_sys, reset                 single clock, synchronous active-high reset
//   ce_pix                         pixel enable; qualifies every video sample
//   VGA_HS/VS, VGA_HB/VB           syncs and blanking, active-high
//   VGA_R/G/B                      pixel colour
//   h_total, h_active              last captured line: length / unblanked samples
//   v_total, v_active              lines per frame / lines whose HS rise saw VB=0
//   frame_sum                      wrap-around sum of {8'h00,R,G,B} over active pixels
//   frame_count                    completed frames since reset
//   line_mismatch                  some line in the frame changed length
//   frame_valid                    one-clk pulse when frame results load
//   stable                         geometry unchanged for STABLE_FRAMES frames
module video_timing_probe #(
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic             VGA_HS,
  input  logic             VGA_VS,
  input  logic             VGA_HB,
  input  logic             VGA_VB,
  input  logic [7:0]       VGA_R,
  input  logic [7:0]       VGA_G,
  input  logic [7:0]       VGA_B,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic [31:0]      frame_sum,
  output logic [15:0]      frame_count,
  output logic             line_mismatch,
  output logic             frame_valid,
  output logic             stable
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]       STABLE_TH = 4'(STABLE_FRAMES);

  // Registered state
  logic             hs_q;
  logic             vs_q;
  logic             h_armed;
  logic             v_armed;
  logic             line_seen;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hact;
  logic [CNT_W-1:0] vcnt;
  logic [CNT_W-1:0] vact;
  logic [CNT_W-1:0] line_len;
  logic [CNT_W-1:0] line_act;
  logic [31:0]      sum_acc;
  logic             mis_acc;
  logic [3:0]       match_cnt;

  // Combinational helpers
  logic             hs_rise;
  logic             vs_rise;
  logic             line_cap;
  logic             frame_cap;
  logic             pix_active;
  logic [31:0]      pix_word;
  logic [CNT_W-1:0] line_len_n;
  logic [CNT_W-1:0] line_act_n;
  logic             mis_n;
  logic             geo_match;
  logic [3:0]       match_cnt_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign hs_rise    = ce_pix & VGA_HS & ~hs_q;
  assign vs_rise    = ce_pix & VGA_VS & ~vs_q;
  assign line_cap   = hs_rise & h_armed;
  assign frame_cap  = vs_rise & v_armed;
  assign pix_active = ~VGA_HB & ~VGA_VB;
  assign pix_word   = {8'h00, VGA_R, VGA_G, VGA_B};

  // Line capture as seen by this sample; a coincident frame capture uses it.
  always_comb begin
    line_len_n = line_len;
    line_act_n = line_act;
    mis_n      = mis_acc;
    if (line_cap) begin
      line_len_n = hcnt;
      line_act_n = hact;
      if (line_seen && (hcnt != line_len)) begin
        mis_n = 1'b1;
      end
    end
  end

  // Stability: compare the incoming frame geometry with the one on the outputs.
  always_comb begin
    geo_match   = (line_len_n == h_total) && (line_act_n == h_active) &&
                  (vcnt == v_total) && (vact == v_active) && !mis_n;
    match_cnt_n = 4'd0;
    if (geo_match) begin
      match_cnt_n = (match_cnt == 4'hF) ? match_cnt : match_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      h_armed       <= 1'b0;
      v_armed       <= 1'b0;
      line_seen     <= 1'b0;
      hcnt          <= '0;
      hact          <= '0;
      vcnt          <= '0;
      vact          <= '0;
      line_len      <= '0;
      line_act      <= '0;
      sum_acc       <= '0;
      mis_acc       <= 1'b0;
      match_cnt     <= 4'd0;
      h_total       <= '0;
      h_active      <= '0;
      v_total       <= '0;
      v_active      <= '0;
      frame_sum     <= '0;
      frame_count   <= '0;
      line_mismatch <= 1'b0;
      frame_valid   <= 1'b0;
      stable        <= 1'b0;
    end else begin
      // frame_cap needs a VS edge, so this is one clk even with ce_pix held high
      frame_valid <= frame_cap;

      if (ce_pix) begin
        hs_q <= VGA_HS;
        vs_q <= VGA_VS;

        // Horizontal: HS rise starts a new line; the rise sample is sample 1
        if (hs_rise) begin
          h_armed <= 1'b1;
          hcnt    <= CNT_W'(1);
          hact    <= VGA_HB ? '0 : CNT_W'(1);
        end else begin
          hcnt <= sat_inc(hcnt);
          if (!VGA_HB) begin
            hact <= sat_inc(hact);
          end
        end

        if (line_cap) begin
          line_seen <= 1'b1;
        end
        line_len <= line_len_n;
        line_act <= line_act_n;

        // Vertical and checksum: a coincident HS rise / pixel opens the new frame
        if (vs_rise) begin
          v_armed <= 1'b1;
          vcnt    <= hs_rise ? CNT_W'(1) : '0;
          vact    <= (hs_rise && !VGA_VB) ? CNT_W'(1) : '0;
          sum_acc <= pix_active ? pix_word : 32'd0;
          mis_acc <= 1'b0;
        end else begin
          if (hs_rise) begin
            vcnt <= sat_inc(vcnt);
            if (!VGA_VB) begin
              vact <= sat_inc(vact);
            end
          end
          if (pix_active) begin
            sum_acc <= sum_acc + pix_word;
          end
          mis_acc <= mis_n;
        end

        // Frame capture loads every result together
        if (frame_cap) begin
          h_total       <= line_len_n;
          h_active      <= line_act_n;
          v_total       <= vcnt;
          v_active      <= vact;
          frame_sum     <= sum_acc;
          line_mismatch <= mis_n;
          frame_count   <= frame_count + 16'd1;
          match_cnt     <= match_cnt_n;
          stable        <= (match_cnt_n >= STABLE_TH);
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_probe.sv
// Self-checking bench for video_timing_probe: synthetic 8-line frames are
// driven, the expected frame result is queued at each armed VS rise and
// compared when frame_valid is seen.
module tb_video_timing_probe;

  logic        clk_sys;
  logic        reset;
  logic        ce_pix;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_HB;
  logic        VGA_VB;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic [11:0] h_total;
  logic [11:0] h_active;
  logic [11:0] v_total;
  logic [11:0] v_active;
  logic [31:0] frame_sum;
  logic [15:0] frame_count;
  logic        line_mismatch;
  logic        frame_valid;
  logic        stable;

  video_timing_probe #(.CNT_W(12), .STABLE_FRAMES(2)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ce_pix       (ce_pix),
    .VGA_HS       (VGA_HS),
    .VGA_VS       (VGA_VS),
    .VGA_HB       (VGA_HB),
    .VGA_VB       (VGA_VB),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B),
    .h_total      (h_total),
    .h_active     (h_active),
    .v_total      (v_total),
    .v_active     (v_active),
    .frame_sum    (frame_sum),
    .frame_count  (frame_count),
    .line_mismatch(line_mismatch),
    .frame_valid  (frame_valid),
    .stable       (stable)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [11:0] ht;
    logic [11:0] ha;
    logic [11:0] vt;
    logic [11:0] va;
    logic [31:0] sum;
    logic        mis;
    logic [15:0] cnt;
    logic        stb;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_cmp    = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_pushed = 0;
  int gap      = 2;

  // Frame-level reference model state
  int          cur_len[8];
  int          prev_len[8];
  logic [31:0] cur_pix;
  logic [31:0] prev_pix;
  int          pp_last7;
  int          m_vs;
  int          m_match;
  logic [15:0] m_count;
  logic [47:0] m_prev_geo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] sat12(input int v);
    return (v > 4095) ? 12'hFFF : 12'(v);
  endfunction

  task automatic model_reset();
    m_vs       = 0;
    m_match    = 0;
    m_count    = 16'd0;
    m_prev_geo = 48'd0;
    pp_last7   = 0;
  endtask

  // Called just before the sample carrying a VS rise; queues the result for
  // the frame that just ended (the previously driven frame).
  task automatic on_vs_rise();
    exp_t        e;
    logic        mis;
    logic [31:0] sum;
    m_vs++;
    if (m_vs >= 2) begin
      mis = 1'b0;
      sum = 32'd0;
      for (int l = 1; l < 8; l++)
        if (sat12(prev_len[l]) != sat12(prev_len[l-1])) mis = 1'b1;
      if (m_vs >= 3 && sat12(prev_len[0]) != sat12(pp_last7)) mis = 1'b1;
      for (int l = 3; l < 8; l++)
        sum = sum + 32'(prev_len[l] - 4) * prev_pix;
      e.ht  = sat12(prev_len[7]);
      e.ha  = sat12(prev_len[7] - 4);
      e.vt  = 12'd8;
      e.va  = 12'd5;
      e.sum = sum;
      e.mis = mis;
      if ({e.ht, e.ha, e.vt, e.va} == m_prev_geo && !mis)
        m_match = (m_match < 15) ? m_match + 1 : 15;
      else
        m_match = 0;
      m_prev_geo = {e.ht, e.ha, e.vt, e.va};
      m_count    = m_count + 16'd1;
      e.cnt      = m_count;
      e.stb      = (m_match >= 2);
      exp_q.push_back(e);
      n_pushed++;
    end
    pp_last7 = prev_len[7];
    for (int l = 0; l < 8; l++) prev_len[l] = cur_len[l];
    prev_pix = cur_pix;
  endtask

  task automatic drive_sample(input logic hs, input logic vs, input logic hb, input logic vb,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    VGA_HS = hs;
    VGA_VS = vs;
    VGA_HB = hb;
    VGA_VB = vb;
    VGA_R  = r;
    VGA_G  = g;
    VGA_B  = b;
    ce_pix = 1'b1;
    @(posedge clk_sys); #1;
    if (gap > 1) begin
      ce_pix = 1'b0;
      repeat (gap - 1) begin
        @(posedge clk_sys); #1;
      end
    end
  endtask

  // Line: HS on sample 0, HB on samples 0..3; VB on lines 0..2; VS two samples at vs_pos of line 0
  task automatic drive_frame(input int n_lines, input int vs_pos,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    cur_pix = {8'h00, r, g, b};
    for (int l = 0; l < n_lines; l++) begin
      for (int s = 0; s < cur_len[l]; s++) begin
        if (l == 0 && s == vs_pos) on_vs_rise();
        drive_sample(s == 0, (l == 0) && (s == vs_pos || s == vs_pos + 1),
                     s < 4, l < 3, r, g, b);
      end
    end
  endtask

  task automatic set_lines(input int len);
    for (int l = 0; l < 8; l++) cur_len[l] = len;
  endtask

  task automatic apply_reset(input bit check_outputs, input string tag);
    reset  = 1'b1;
    ce_pix = 1'b0;
    VGA_HS = 1'b0;
    VGA_VS = 1'b0;
    VGA_HB = 1'b0;
    VGA_VB = 1'b0;
    @(posedge clk_sys); #1;
    if (check_outputs) begin
      check({tag, "_h_total"},       32'(h_total),       32'd0);
      check({tag, "_h_active"},      32'(h_active),      32'd0);
      check({tag, "_v_total"},       32'(v_total),       32'd0);
      check({tag, "_v_active"},      32'(v_active),      32'd0);
      check({tag, "_frame_sum"},     frame_sum,          32'd0);
      check({tag, "_frame_count"},   32'(frame_count),   32'd0);
      check({tag, "_line_mismatch"}, 32'(line_mismatch), 32'd0);
      check({tag, "_frame_valid"},   32'(frame_valid),   32'd0);
      check({tag, "_stable"},        32'(stable),        32'd0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  // Scoreboard consumer: every frame_valid cycle must match a queued frame
  always @(negedge clk_sys) begin
    if (!reset && frame_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("h_total",       32'(h_total),       32'(mon_e.ht));
        check("h_active",      32'(h_active),      32'(mon_e.ha));
        check("v_total",       32'(v_total),       32'(mon_e.vt));
        check("v_active",      32'(v_active),      32'(mon_e.va));
        check("frame_sum",     frame_sum,          mon_e.sum);
        check("line_mismatch", 32'(line_mismatch), 32'(mon_e.mis));
        check("frame_count",   32'(frame_count),   32'(mon_e.cnt));
        check("stable",        32'(stable),        32'(mon_e.stb));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    ce_pix = 1'b0;
    VGA_HS = 1'b0;
    VGA_VS = 1'b0;
    VGA_HB = 1'b0;
    VGA_VB = 1'b0;
    VGA_R  = 8'h00;
    VGA_G  = 8'h00;
    VGA_B  = 8'h00;
    set_lines(10);
    for (int l = 0; l < 8; l++) prev_len[l] = 10;
    cur_pix  = 32'd0;
    prev_pix = 32'd0;
    repeat (2) @(posedge clk_sys);
    apply_reset(1'b1, "reset");

    // Sparse ce_pix, steady 10x8 frames; frame 5 has one 11-sample line
    gap = 2;
    for (int f = 0; f < 9; f++) begin
      set_lines(10);
      if (f == 5) cur_len[4] = 11;
      drive_frame(8, 5, 8'h01, (f == 7) ? 8'h22 : 8'h00, (f == 7) ? 8'h05 : 8'h00);
    end

    // Partial frame, then reset mid-frame; two VS rises needed before next result
    set_lines(10);
    drive_frame(4, 5, 8'h01, 8'h00, 8'h00);
    apply_reset(1'b1, "midreset");

    gap = 3;
    for (int f = 0; f < 3; f++) begin
      set_lines(10);
      drive_frame(8, 5, 8'h00, 8'h10, 8'h00);
    end

    // ce_pix held high, HS and VS rising on the same sample
    apply_reset(1'b0, "");
    gap = 1;
    for (int f = 0; f < 3; f++) begin
      set_lines(10);
      drive_frame(8, 0, 8'h00, 8'h00, 8'hFF);
    end

    // A line longer than 4095 samples saturates the horizontal counters
    apply_reset(1'b0, "");
    gap = 1;
    set_lines(10);
    cur_len[7] = 4200;
    drive_frame(8, 5, 8'h01, 8'h00, 8'h00);
    set_lines(10);
    drive_frame(8, 5, 8'h01, 8'h00, 8'h00);

    ce_pix = 1'b0;
    repeat (10) @(posedge clk_sys);
    #1;
    check("frame_valid_pulses", 32'(n_valid), 32'(n_pushed));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
